// File: rtl/hilo_seq.sv
// hilo_seq: execute-stage sequencer for HI/LO-class ops. Drives an external
// pipelined unsigned multiplier and a stream divider, and owns HI/LO.
module hilo_seq #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [12:0] req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        div_tvalid,
    input  logic        div_tready,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_dout_tvalid,
    input  logic [63:0] div_dout_tdata,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_SEND,
        S_DIV_WAIT,
        S_DIV_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_ADD,
        ACC_SUB
    } acc_e;

    state_e           state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_result_q, resp_result_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;
    logic             neg_q, neg_d;
    acc_e             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_tvalid_q, div_tvalid_d;
    logic             div_signed_q, div_signed_d;
    logic [31:0]      div_dividend_q, div_dividend_d;
    logic [31:0]      div_divisor_q, div_divisor_d;

    logic        accept;
    logic        op_onehot;
    logic        op_move;
    logic        op_mul;
    logic        op_div;
    logic        op_mul_signed;
    logic [31:0] abs_src1;
    logic [31:0] abs_src2;
    logic [63:0] hilo;
    logic [63:0] prod;
    logic [63:0] mul_res;

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = req_valid & req_ready & ~flush;

    // Malformed opcodes (zero or several bits set) fall through every class and
    // get a zero response without touching HI/LO.
    assign op_onehot     = (req_op != '0) && ((req_op & (req_op - 13'd1)) == '0);
    assign op_move       = op_onehot & (|req_op[3:0]);
    assign op_div        = op_onehot & (|req_op[5:4]);
    assign op_mul        = op_onehot & (|req_op[12:6]);
    assign op_mul_signed = req_op[6] | req_op[8] | req_op[9] | req_op[11];

    assign abs_src1 = req_src1[31] ? (~req_src1 + 32'd1) : req_src1;
    assign abs_src2 = req_src2[31] ? (~req_src2 + 32'd1) : req_src2;

    // The multiplier works on magnitudes; the sign is restored here, mod 2^64.
    assign hilo    = {hi_q, lo_q};
    assign prod    = neg_q ? (~mul_p + 64'd1) : mul_p;
    assign mul_res = (acc_q == ACC_ADD) ? (hilo + prod) :
                     (acc_q == ACC_SUB) ? (hilo - prod) : prod;

    // Next-state and datapath updates; flush suppresses every write and response.
    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        resp_valid_d   = 1'b0;
        resp_result_d  = resp_result_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        neg_d          = neg_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        div_tvalid_d   = div_tvalid_q;
        div_signed_d   = div_signed_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_move) begin
                        resp_valid_d = 1'b1;
                        if (req_op[0]) begin
                            hi_d          = req_src1;
                            resp_result_d = req_src1;
                        end else if (req_op[1]) begin
                            lo_d          = req_src1;
                            resp_result_d = req_src1;
                        end else if (req_op[2]) begin
                            resp_result_d = hi_q;
                        end else begin
                            resp_result_d = lo_q;
                        end
                    end else if (op_mul) begin
                        cnt_d   = '0;
                        state_d = S_MUL;
                        if (op_mul_signed) begin
                            mul_a_d = abs_src1;
                            mul_b_d = abs_src2;
                            neg_d   = req_src1[31] ^ req_src2[31];
                        end else begin
                            mul_a_d = req_src1;
                            mul_b_d = req_src2;
                            neg_d   = 1'b0;
                        end
                        if (req_op[9] | req_op[10]) begin
                            acc_d = ACC_ADD;
                        end else if (req_op[11] | req_op[12]) begin
                            acc_d = ACC_SUB;
                        end else begin
                            acc_d = ACC_NONE;
                        end
                    end else if (op_div) begin
                        div_dividend_d = req_src1;
                        div_divisor_d  = req_src2;
                        div_signed_d   = req_op[4];
                        div_tvalid_d   = 1'b1;
                        state_d        = S_DIV_SEND;
                    end else begin
                        resp_valid_d  = 1'b1;
                        resp_result_d = '0;
                    end
                end
            end

            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    hi_d          = mul_res[63:32];
                    lo_d          = mul_res[31:0];
                    resp_result_d = mul_res[31:0];
                    resp_valid_d  = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DIV_SEND: begin
                // A beat the divider already took must be drained even if flushed.
                if (div_tready) begin
                    div_tvalid_d = 1'b0;
                    state_d      = flush ? S_DIV_DRAIN : S_DIV_WAIT;
                end else if (flush) begin
                    div_tvalid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            S_DIV_WAIT: begin
                if (flush) begin
                    state_d = div_dout_tvalid ? S_IDLE : S_DIV_DRAIN;
                end else if (div_dout_tvalid) begin
                    lo_d          = div_dout_tdata[63:32];
                    hi_d          = div_dout_tdata[31:0];
                    resp_result_d = div_dout_tdata[63:32];
                    resp_valid_d  = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            S_DIV_DRAIN: begin
                if (div_dout_tvalid) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            hi_q           <= '0;
            lo_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_result_q  <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            neg_q          <= 1'b0;
            acc_q          <= ACC_NONE;
            cnt_q          <= '0;
            div_tvalid_q   <= 1'b0;
            div_signed_q   <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            resp_valid_q   <= resp_valid_d;
            resp_result_q  <= resp_result_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            neg_q          <= neg_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            div_tvalid_q   <= div_tvalid_d;
            div_signed_q   <= div_signed_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign resp_valid   = resp_valid_q;
    assign resp_result  = resp_result_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign div_tvalid   = div_tvalid_q;
    assign div_signed   = div_signed_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_hilo_seq.sv
// tb_hilo_seq: directed vectors for hilo_seq with a pipelined multiplier
// and a stream divider whose ready delay and latency are adjustable.
module tb_hilo_seq;

    localparam int MUL_LAT = 3;

    localparam logic [12:0] OP_MTHI  = 13'h0001;
    localparam logic [12:0] OP_MTLO  = 13'h0002;
    localparam logic [12:0] OP_MFHI  = 13'h0004;
    localparam logic [12:0] OP_MFLO  = 13'h0008;
    localparam logic [12:0] OP_DIV   = 13'h0010;
    localparam logic [12:0] OP_DIVU  = 13'h0020;
    localparam logic [12:0] OP_MULT  = 13'h0040;
    localparam logic [12:0] OP_MULTU = 13'h0080;
    localparam logic [12:0] OP_MUL   = 13'h0100;
    localparam logic [12:0] OP_MADDU = 13'h0400;
    localparam logic [12:0] OP_MSUB  = 13'h0800;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [12:0] req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        div_tvalid;
    logic        div_tready;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_dout_tvalid;
    logic [63:0] div_dout_tdata;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int vectorCount = 0;
    int missCount   = 0;
    int cycleNum    = 0;

    int readyHoldCfg  = 0;
    int divLatencyCfg = 4;
    int lastDoutCycle = -100;

    hilo_seq #(.MUL_LAT(MUL_LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_src1        (req_src1),
        .req_src2        (req_src2),
        .flush           (flush),
        .mul_a           (mul_a),
        .mul_b           (mul_b),
        .mul_p           (mul_p),
        .div_tvalid      (div_tvalid),
        .div_tready      (div_tready),
        .div_signed      (div_signed),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_dout_tvalid (div_dout_tvalid),
        .div_dout_tdata  (div_dout_tdata),
        .resp_valid      (resp_valid),
        .resp_result     (resp_result),
        .hi              (hi),
        .lo              (lo),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    // Product is ready MUL_LAT-1 stages after the registered operands, i.e.
    // in the cycle where the sequencer samples it.
    logic [63:0] mulP1, mulP2;
    always @(posedge clk) begin
        mulP1 <= {32'b0, mul_a} * {32'b0, mul_b};
        mulP2 <= mulP1;
    end
    assign mul_p = mulP2;

    // Divider: holds tready low readyHoldCfg cycles, answers divLatencyCfg later.
    initial begin : dividerModel
        int holdLeft;
        int countdown;
        bit pending;
        logic [63:0] result;
        holdLeft = 0;
        countdown = 0;
        pending = 1'b0;
        result = '0;
        div_tready = 1'b0;
        div_dout_tvalid = 1'b0;
        div_dout_tdata = '0;
        forever begin
            @(posedge clk);
            #2;
            div_dout_tvalid = 1'b0;
            if (pending) begin
                if (countdown <= 1) begin
                    div_dout_tvalid = 1'b1;
                    div_dout_tdata  = result;
                    pending         = 1'b0;
                    lastDoutCycle   = cycleNum;
                end else begin
                    countdown--;
                end
            end
            if (div_tvalid && !pending) begin
                if (holdLeft > 0) begin
                    div_tready = 1'b0;
                    holdLeft--;
                end else begin
                    div_tready = 1'b1;
                    pending    = 1'b1;
                    countdown  = divLatencyCfg;
                    if (div_divisor == 32'd0) begin
                        result = '1;
                    end else if (div_signed) begin
                        result = {32'($signed(div_dividend) / $signed(div_divisor)),
                                  32'($signed(div_dividend) % $signed(div_divisor))};
                    end else begin
                        result = {div_dividend / div_divisor, div_dividend % div_divisor};
                    end
                end
            end else begin
                div_tready = 1'b0;
                holdLeft   = readyHoldCfg;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns in cycle A+1.
    task automatic applyStimulus(input string tag, input logic [12:0] op,
                                 input logic [31:0] s1, input logic [31:0] s2);
        checkOutput({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = s1;
        req_src2  = s2;
        nextCycle();
        req_valid = 1'b0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
    endtask

    // Called in cycle A+1; latency 1 means resp_valid at A+1.
    task automatic waitResp(input string tag, input int expLat);
        int lat;
        lat = 1;
        while (!resp_valid && lat <= 40) begin
            nextCycle();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    endtask

    task automatic runOp(input string tag, input logic [12:0] op,
                         input logic [31:0] s1, input logic [31:0] s2, input int expLat,
                         input logic [31:0] expRes, input logic [31:0] expHi,
                         input logic [31:0] expLo);
        applyStimulus(tag, op, s1, s2);
        waitResp(tag, expLat);
        checkOutput({tag, "_result"}, resp_result, expRes);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
    endtask

    task automatic expectQuiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (resp_valid) seen = 1'b1;
            nextCycle();
        end
        checkOutput({tag, "_no_resp"}, seen, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        bit seen;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
        flush     = 1'b0;

        #2;
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_result", resp_result, 0);
        checkOutput("rst_div_tvalid", div_tvalid, 0);
        checkOutput("rst_div_signed", div_signed, 0);
        checkOutput("rst_mul_ab", {mul_a, mul_b}, 0);
        checkOutput("rst_div_ops", {div_dividend, div_divisor}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // mthi then back-to-back mfhi
        applyStimulus("mthi", OP_MTHI, 32'h12345678, 32'h0);
        checkOutput("mthi_resp_valid", resp_valid, 1);
        checkOutput("mthi_result", resp_result, 32'h12345678);
        checkOutput("mthi_hi", hi, 32'h12345678);
        applyStimulus("mfhi", OP_MFHI, 32'h0, 32'h0);
        checkOutput("mfhi_resp_valid", resp_valid, 1);
        checkOutput("mfhi_result", resp_result, 32'h12345678);

        runOp("mtlo", OP_MTLO, 32'hCAFEF00D, 32'h0, 1, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);
        runOp("mflo", OP_MFLO, 32'h0, 32'h0, 1, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);

        runOp("op_zero", 13'h0000, 32'hDEAD0000, 32'h1, 1, 32'h0, 32'h12345678, 32'hCAFEF00D);
        runOp("op_twohot", 13'h0005, 32'hDEAD0001, 32'h1, 1, 32'h0, 32'h12345678, 32'hCAFEF00D);

        // Request presented with flush in IDLE is refused
        nextCycle();
        flush = 1'b1;
        applyStimulus("idle_flush", OP_MTHI, 32'h55555555, 32'h0);
        flush = 1'b0;
        checkOutput("idle_flush_resp", resp_valid, 0);
        checkOutput("idle_flush_busy", busy, 0);
        checkOutput("idle_flush_hi", hi, 32'h12345678);

        // Signed multiply, check operands and exact latency
        applyStimulus("mult", OP_MULT, 32'hFFFFFFFE, 32'h00000003);
        checkOutput("mult_mul_a", mul_a, 32'h2);
        checkOutput("mult_mul_b", mul_b, 32'h3);
        checkOutput("mult_busy", busy, 1);
        checkOutput("mult_ready", req_ready, 0);
        waitResp("mult", MUL_LAT + 1);
        checkOutput("mult_result", resp_result, 32'hFFFFFFFA);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFA);

        runOp("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 32'h00000001, 32'hFFFFFFFE, 32'h00000001);
        runOp("maddu", OP_MADDU, 32'hFFFFFFFF, 32'h00000001, 4, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);
        runOp("msub", OP_MSUB, 32'hFFFFFFFD, 32'h00000005, 4, 32'h0000000F, 32'hFFFFFFFF, 32'h0000000F);
        runOp("mul_min", OP_MUL, 32'h80000000, 32'hFFFFFFFF, 4, 32'h80000000, 32'h00000000, 32'h80000000);

        // Signed divide with ready held off for two cycles
        readyHoldCfg  = 2;
        divLatencyCfg = 10;
        applyStimulus("div", OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        for (int i = 0; i < 3; i++) begin
            checkOutput("div_tvalid_held", div_tvalid, 1);
            checkOutput("div_operands", {div_dividend, div_divisor}, 64'hFFFFFFF9_00000002);
            checkOutput("div_signed", div_signed, 1);
            nextCycle();
        end
        checkOutput("div_tvalid_drop", div_tvalid, 0);
        n = 0;
        while (!resp_valid && n < 40) begin
            nextCycle();
            n++;
        end
        checkOutput("div_resp_timing", 64'(cycleNum), 64'(lastDoutCycle + 1));
        checkOutput("div_result", resp_result, 32'hFFFFFFFD);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);

        readyHoldCfg  = 0;
        divLatencyCfg = 3;
        applyStimulus("divu", OP_DIVU, 32'hFFFFFFF9, 32'h00000002);
        checkOutput("divu_signed", div_signed, 0);
        waitResp("divu", 5);
        checkOutput("divu_result", resp_result, 32'h7FFFFFFC);
        checkOutput("divu_lo", lo, 32'h7FFFFFFC);
        checkOutput("divu_hi", hi, 32'h00000001);

        // Flush during MUL
        applyStimulus("mul_flush", OP_MULT, 32'd7, 32'd9);
        nextCycle();
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        checkOutput("mul_flush_busy", busy, 0);
        checkOutput("mul_flush_ready", req_ready, 1);
        expectQuiet("mul_flush", 5);
        checkOutput("mul_flush_hilo", {hi, lo}, 64'h00000001_7FFFFFFC);

        // Flush in DIV_SEND before the divider takes the beat
        readyHoldCfg = 3;
        applyStimulus("send_flush", OP_DIV, 32'd100, 32'd7);
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        checkOutput("send_flush_tvalid", div_tvalid, 0);
        checkOutput("send_flush_busy", busy, 0);
        expectQuiet("send_flush", 6);
        checkOutput("send_flush_hilo", {hi, lo}, 64'h00000001_7FFFFFFC);

        // Flush in DIV_WAIT: drain, then HI must be untouched
        readyHoldCfg  = 0;
        divLatencyCfg = 6;
        runOp("mthi_aa", OP_MTHI, 32'h000000AA, 32'h0, 1, 32'h000000AA, 32'h000000AA, 32'h7FFFFFFC);
        applyStimulus("wait_flush", OP_DIV, 32'd100, 32'd7);
        nextCycle();
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        checkOutput("drain_ready", req_ready, 0);
        seen = 1'b0;
        n = 0;
        while (!req_ready && n < 40) begin
            if (resp_valid) seen = 1'b1;
            nextCycle();
            n++;
        end
        checkOutput("drain_no_resp", seen, 0);
        checkOutput("drain_exit_timing", 64'(cycleNum), 64'(lastDoutCycle + 1));
        checkOutput("drain_exit_resp", resp_valid, 0);
        runOp("mfhi_after_drain", OP_MFHI, 32'h0, 32'h0, 1, 32'h000000AA, 32'h000000AA, 32'h7FFFFFFC);

        // Asynchronous reset in the second MUL cycle
        applyStimulus("rst_mul", OP_MULTU, 32'd5, 32'd6);
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ready", req_ready, 1);
        checkOutput("midrst_hilo", {hi, lo}, 0);
        checkOutput("midrst_mul_ab", {mul_a, mul_b}, 0);
        checkOutput("midrst_resp", {31'b0, resp_valid, resp_result}, 0);
        #2;
        reset = 1'b1;
        nextCycle();
        expectQuiet("midrst", 4);
        runOp("mflo_after_rst", OP_MFLO, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
